// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM arbiter slice.
package vram_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 8;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_CPU,
    GNT_DMA
  } gnt_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its three users and the single-port VRAM.
interface vram_arbiter_if;

  logic                         vid_req;
  logic [vram_pkg::VRAM_AW-1:0] vid_addr;
  logic [vram_pkg::VRAM_DW-1:0] vid_data;
  logic                         vid_valid;
  logic                         vid_miss;

  logic                         cpu_req;
  logic                         cpu_we;
  logic [vram_pkg::VRAM_AW-1:0] cpu_addr;
  logic [vram_pkg::VRAM_DW-1:0] cpu_wdata;
  logic [vram_pkg::VRAM_DW-1:0] cpu_rdata;
  logic                         cpu_ack;

  logic                         dma_req;
  logic                         dma_we;
  logic [vram_pkg::VRAM_AW-1:0] dma_addr;
  logic [vram_pkg::VRAM_DW-1:0] dma_wdata;
  logic [vram_pkg::VRAM_DW-1:0] dma_rdata;
  logic                         dma_ack;

  logic [vram_pkg::VRAM_AW-1:0] ram_addr;
  logic                         ram_we;
  logic [vram_pkg::VRAM_DW-1:0] ram_wdata;
  logic [vram_pkg::VRAM_DW-1:0] ram_rdata;

  // Requesters and RAM side.
  modport master (
    output vid_req, vid_addr,
    input  vid_data, vid_valid, vid_miss,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

  // Arbiter side.
  modport slave (
    input  vid_req, vid_addr,
    output vid_data, vid_valid, vid_miss,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/vram_req_port.sv
// Per-requester state for CPU/DMA: wait counter, ack and read-data registers, eligibility.
module vram_req_port
  import vram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_i,
  input  logic               we_i,
  input  logic               grant_i,
  input  logic [VRAM_DW-1:0] ram_rdata_i,
  output logic               eligible_o,
  output logic               forced_o,
  output logic               ack_o,
  output logic [VRAM_DW-1:0] rdata_o
);

  localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               ack_q;
  logic               rd_q;
  logic [VRAM_DW-1:0] rdata_q;

  // The ack cycle is dead time so a held req is seen as a fresh access.
  assign eligible_o = req_i & ~ack_q;
  assign forced_o   = eligible_o & (wait_q == WaitMax);

  always_comb begin
    wait_d = wait_q;
    if (grant_i || !req_i) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      wait_q <= wait_d;
      ack_q  <= grant_i;
      rd_q   <= grant_i & ~we_i;
      if (rd_q) begin
        rdata_q <= ram_rdata_i;
      end
    end
  end

  // Synchronous RAM data arrives in the response cycle; pass it through, then hold it.
  assign ack_o   = ack_q;
  assign rdata_o = rd_q ? ram_rdata_i : rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch on top, CPU/DMA round-robin with anti-starvation.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input logic           clk,
  input logic           reset_n,
  vram_arbiter_if.slave bus
);

  gnt_e               grant;
  gnt_e               rr_pick;
  gnt_e               inflight_q;
  gnt_e               last_q, last_d;
  logic               cpu_elig, cpu_forced;
  logic               dma_elig, dma_forced;
  logic               vid_miss_q;
  logic [VRAM_DW-1:0] vid_data_q;

  vram_req_port #(
    .MAX_WAIT (MAX_WAIT)
  ) u_cpu_port (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (bus.cpu_req),
    .we_i        (bus.cpu_we),
    .grant_i     (grant == GNT_CPU),
    .ram_rdata_i (bus.ram_rdata),
    .eligible_o  (cpu_elig),
    .forced_o    (cpu_forced),
    .ack_o       (bus.cpu_ack),
    .rdata_o     (bus.cpu_rdata)
  );

  vram_req_port #(
    .MAX_WAIT (MAX_WAIT)
  ) u_dma_port (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (bus.dma_req),
    .we_i        (bus.dma_we),
    .grant_i     (grant == GNT_DMA),
    .ram_rdata_i (bus.ram_rdata),
    .eligible_o  (dma_elig),
    .forced_o    (dma_forced),
    .ack_o       (bus.dma_ack),
    .rdata_o     (bus.dma_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= GNT_NONE;
      last_q     <= GNT_DMA;
      vid_miss_q <= 1'b0;
      vid_data_q <= '0;
    end else begin
      inflight_q <= grant;
      last_q     <= last_d;
      // A forced grant always displaces a coincident video strobe.
      vid_miss_q <= bus.vid_req & (cpu_forced | dma_forced);
      if (inflight_q == GNT_VID) begin
        vid_data_q <= bus.ram_rdata;
      end
    end
  end

  // Gating on reset keeps the RAM port quiet while reset is held.
  always_comb begin
    rr_pick = (last_q == GNT_CPU) ? GNT_DMA : GNT_CPU;
    grant   = GNT_NONE;
    last_d  = last_q;
    if (!reset_n) begin
      grant = GNT_NONE;
    end else if (cpu_forced && dma_forced) begin
      grant = rr_pick;
    end else if (cpu_forced) begin
      grant = GNT_CPU;
    end else if (dma_forced) begin
      grant = GNT_DMA;
    end else if (bus.vid_req) begin
      grant = GNT_VID;
    end else if (cpu_elig && dma_elig) begin
      grant = rr_pick;
    end else if (cpu_elig) begin
      grant = GNT_CPU;
    end else if (dma_elig) begin
      grant = GNT_DMA;
    end
    if (grant == GNT_CPU || grant == GNT_DMA) begin
      last_d = grant;
    end
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    case (grant)
      GNT_VID: bus.ram_addr = bus.vid_addr;
      GNT_CPU: begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_we    = bus.cpu_we;
        bus.ram_wdata = bus.cpu_wdata;
      end
      GNT_DMA: begin
        bus.ram_addr  = bus.dma_addr;
        bus.ram_we    = bus.dma_we;
        bus.ram_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign bus.vid_valid = (inflight_q == GNT_VID);
  assign bus.vid_data  = bus.vid_valid ? bus.ram_rdata : vid_data_q;
  assign bus.vid_miss  = vid_miss_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter against a cycle-level reference model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned MaxWait = 8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic [7:0] ram_mem [8192];
  logic [7:0] ref_mem [8192];

  // Reference model state
  int         cnt_c, cnt_d;
  bit         last_cpu;
  bit         m_ack_c, m_ack_d, m_valid, m_miss;
  logic [7:0] m_rd_c, m_rd_d, m_vdata;
  acc_t       cpu_s, dma_s;

  always #5 clk = ~clk;

  vram_arbiter_if bus ();

  vram_arbiter #(
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cnt_c = 0; cnt_d = 0; last_cpu = 1'b0;
    m_ack_c = 0; m_ack_d = 0; m_valid = 0; m_miss = 0;
    m_rd_c = '0; m_rd_d = '0; m_vdata = '0;
  endtask

  task automatic drive();
    bus.cpu_req = cpu_s.req; bus.cpu_we = cpu_s.we;
    bus.cpu_addr = cpu_s.addr; bus.cpu_wdata = cpu_s.wdata;
    bus.dma_req = dma_s.req; bus.dma_we = dma_s.we;
    bus.dma_addr = dma_s.addr; bus.dma_wdata = dma_s.wdata;
  endtask

  // Synchronous read-first RAM, one clock, ending on the following falling edge.
  task automatic ram_cycle();
    logic [12:0] a;
    logic        w;
    logic [7:0]  d;
    a = bus.ram_addr; w = bus.ram_we; d = bus.ram_wdata;
    @(posedge clk);
    bus.ram_rdata <= ram_mem[a];
    if (w) ram_mem[a] = d;
    @(negedge clk);
  endtask

  task automatic check_outputs(input string pfx);
    check_eq({pfx, "cpu_ack"},   bus.cpu_ack,   m_ack_c);
    check_eq({pfx, "cpu_rdata"}, bus.cpu_rdata, m_rd_c);
    check_eq({pfx, "dma_ack"},   bus.dma_ack,   m_ack_d);
    check_eq({pfx, "dma_rdata"}, bus.dma_rdata, m_rd_d);
    check_eq({pfx, "vid_valid"}, bus.vid_valid, m_valid);
    check_eq({pfx, "vid_data"},  bus.vid_data,  m_vdata);
    check_eq({pfx, "vid_miss"},  bus.vid_miss,  m_miss);
  endtask

  // One clock: decide who owns the RAM from the priority rules, then check the response.
  task automatic tick();
    int          g;  // 0 none, 1 video, 2 cpu, 3 dma
    bit          want_c, want_d, urgent_c, urgent_d, cpu_turn;
    logic [12:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wdata;
    drive();
    #1;
    want_c   = cpu_s.req && !m_ack_c;
    want_d   = dma_s.req && !m_ack_d;
    urgent_c = want_c && (cnt_c >= int'(MaxWait));
    urgent_d = want_d && (cnt_d >= int'(MaxWait));
    cpu_turn = !last_cpu;
    if (urgent_c || urgent_d)       g = (urgent_c && urgent_d) ? (cpu_turn ? 2 : 3) : (urgent_c ? 2 : 3);
    else if (bus.vid_req)           g = 1;
    else if (want_c && want_d)      g = cpu_turn ? 2 : 3;
    else if (want_c || want_d)      g = want_c ? 2 : 3;
    else                            g = 0;

    exp_addr  = (g == 1) ? bus.vid_addr : (g == 2) ? cpu_s.addr : (g == 3) ? dma_s.addr : 13'h0;
    exp_we    = (g == 2) ? cpu_s.we : (g == 3) ? dma_s.we : 1'b0;
    exp_wdata = (g == 2) ? cpu_s.wdata : dma_s.wdata;
    check_eq("ram_we", bus.ram_we, exp_we);
    if (g != 0) check_eq("ram_addr", bus.ram_addr, exp_addr);
    if (exp_we) check_eq("ram_wdata", bus.ram_wdata, exp_wdata);

    m_ack_c = (g == 2);
    m_ack_d = (g == 3);
    m_valid = (g == 1);
    m_miss  = bus.vid_req && (urgent_c || urgent_d);
    if (g == 1) m_vdata = ref_mem[bus.vid_addr];
    if (g == 2) begin
      if (cpu_s.we) ref_mem[cpu_s.addr] = cpu_s.wdata;
      else          m_rd_c = ref_mem[cpu_s.addr];
      last_cpu = 1'b1;
    end
    if (g == 3) begin
      if (dma_s.we) ref_mem[dma_s.addr] = dma_s.wdata;
      else          m_rd_d = ref_mem[dma_s.addr];
      last_cpu = 1'b0;
    end
    cnt_c = (g == 2 || !cpu_s.req) ? 0 : ((cnt_c < int'(MaxWait)) ? cnt_c + 1 : cnt_c);
    cnt_d = (g == 3 || !dma_s.req) ? 0 : ((cnt_d < int'(MaxWait)) ? cnt_d + 1 : cnt_d);

    ram_cycle();
    check_outputs("");
  endtask

  function automatic acc_t next_acc(acc_t cur, bit acked);
    acc_t n = cur;
    if ((!cur.req && $urandom_range(99) < 35) || (cur.req && acked && $urandom_range(1) == 1)) begin
      n.req   = 1'b1;
      n.we    = 1'($urandom_range(1));
      n.addr  = ($urandom_range(9) == 0) ? 13'($urandom) : 13'($urandom_range(31));
      n.wdata = 8'($urandom);
    end else if (cur.req && acked) begin
      n.req = 1'b0;
    end
    return n;
  endfunction

  initial begin
    int n, misses, t_c, t_d, pct;
    for (int i = 0; i < 8192; i++) begin
      ram_mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = ram_mem[i];
    end
    cpu_s = '0; dma_s = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0; bus.ram_rdata = '0;
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Video only, strobe on alternate cycles
    for (int i = 0; i < 40; i++) begin
      bus.vid_req = 1'b0; tick();
      bus.vid_req = 1'b1; bus.vid_addr = 13'(i); tick();
    end
    bus.vid_req = 1'b0;

    // CPU write then read back
    cpu_s = '{req: 1'b1, we: 1'b1, addr: 13'h1ABC, wdata: 8'hA5};
    tick();
    check_eq("cpu_wr_ack", bus.cpu_ack, 1'b1);
    cpu_s.req = 1'b0; tick();
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 13'h1ABC, wdata: 8'h00};
    tick();
    check_eq("cpu_rd_ack", bus.cpu_ack, 1'b1);
    check_eq("cpu_rd_data", bus.cpu_rdata, 8'hA5);
    cpu_s.req = 1'b0; tick();

    // Tie straight after reset: CPU first
    reset_n = 1'b0; model_reset(); tick(); reset_n = 1'b1;
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 13'h0010, wdata: 8'h00};
    dma_s = '{req: 1'b1, we: 1'b0, addr: 13'h0020, wdata: 8'h00};
    tick();
    check_eq("tie_cpu_ack", bus.cpu_ack, 1'b1);
    check_eq("tie_dma_wait", bus.dma_ack, 1'b0);
    cpu_s.req = 1'b0; tick();
    check_eq("tie_dma_ack", bus.dma_ack, 1'b1);
    dma_s.req = 1'b0; tick();

    // Starvation under continuous video
    bus.vid_req = 1'b1;
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 13'h0100, wdata: 8'h00};
    n = 0; misses = 0;
    while (n < 20 && !bus.cpu_ack) begin
      bus.vid_addr = 13'($urandom_range(63));
      tick(); n++;
      if (bus.vid_miss) misses++;
    end
    check_eq("starve_latency", n, 9);
    check_eq("starve_misses", misses, 1);
    cpu_s.req = 1'b0; bus.vid_req = 1'b0; tick();

    // Both counters saturate together with CPU served last
    bus.vid_req = 1'b1;
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 13'h0101, wdata: 8'h00};
    dma_s = '{req: 1'b1, we: 1'b0, addr: 13'h0102, wdata: 8'h00};
    n = 0; misses = 0; t_c = 0; t_d = 0;
    while (n < 24 && (t_c == 0 || t_d == 0)) begin
      tick(); n++;
      if (bus.vid_miss) misses++;
      if (bus.cpu_ack) begin t_c = n; cpu_s.req = 1'b0; end
      if (bus.dma_ack) begin t_d = n; dma_s.req = 1'b0; end
    end
    check_eq("sat_dma_first", t_d, 9);
    check_eq("sat_cpu_next", t_c, 10);
    check_eq("sat_misses", misses, 2);
    bus.vid_req = 1'b0; tick();

    // Reset asserted in a CPU read grant cycle
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 13'h0005, wdata: 8'h00};
    drive(); #1;
    reset_n = 1'b0; #1;
    check_eq("rst_ram_we", bus.ram_we, 1'b0);
    check_eq("rst_ram_addr", bus.ram_addr, 13'h0);
    model_reset();
    check_outputs("rst_");
    ram_cycle();
    check_outputs("rst_hold_");
    cpu_s.req = 1'b0;
    reset_n = 1'b1;
    tick();
    cpu_s = '{req: 1'b1, we: 1'b0, addr: 13'h1ABC, wdata: 8'h00};
    tick();
    check_eq("post_rst_data", bus.cpu_rdata, 8'hA5);
    cpu_s.req = 1'b0; tick();

    // Random traffic at rising video load
    for (int seg = 0; seg < 3; seg++) begin
      pct = seg * 45;
      for (int k = 0; k < 700; k++) begin
        bus.vid_req  = ($urandom_range(99) < pct);
        bus.vid_addr = 13'($urandom_range(63));
        cpu_s = next_acc(cpu_s, m_ack_c);
        dma_s = next_acc(dma_s, m_ack_d);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
